// File: rtl/keycode_decoder.sv
// keycode_decoder: qualifies keypad codes, builds a 3-digit entry buffer and scans it onto a 7-seg display
module keycode_decoder #(
   parameter int HOLD_CYCLES = 2,
   parameter int SCAN_DIV    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  code_in,
   input  logic        clr,
   output logic        key_stb,
   output logic        err_stb,
   output logic [9:0]  line_out,
   output logic [11:0] digits,
   output logic [1:0]  count,
   output logic        full,
   output logic [2:0]  seg_sel,
   output logic [6:0]  seg_out
);
   localparam logic [3:0] HOLD      = 4'(HOLD_CYCLES);
   localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);
   typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;
   state_t      state_q, state_d;
   logic [4:0]  code_q;
   logic [3:0]  cnt_q, cnt_d;
   logic        key_stb_q, key_stb_d, err_stb_q, err_stb_d;
   logic [9:0]  line_q, line_d;
   logic [11:0] digits_q, digits_d, base_digits;
   logic [1:0]  count_q, count_d, base_count;
   logic [7:0]  scan_q, scan_d;
   logic [2:0]  sel_q, sel_d;
   logic        stable, accept, legal;
   logic [1:0]  pos;
   logic [3:0]  shown;
   logic [6:0]  seg_raw;
   // next state: stability counter saturating at HOLD, press FSM, entry buffer, scan rotation
   always_comb begin
      stable      = cnt_q == HOLD;
      cnt_d       = code_in != code_q ? 4'd0 : stable ? cnt_q : cnt_q + 4'd1;
      accept      = state_q == QUAL && stable && code_q[4];
      legal       = code_q[3:0] <= 4'd9;
      state_d     = state_q == IDLE ? (code_q[4] ? QUAL : IDLE)
                  : state_q == QUAL ? (!code_q[4] ? IDLE : stable ? HELD : QUAL)
                  : (!code_q[4] && stable ? IDLE : HELD);
      key_stb_d   = accept && legal;
      err_stb_d   = accept && !legal;
      line_d      = key_stb_d ? 10'd1 << code_q[3:0]
                  : state_q == HELD && state_d == IDLE ? 10'd0 : line_q;
      base_digits = clr ? 12'd0 : digits_q;
      base_count  = clr ? 2'd0 : count_q;
      digits_d    = key_stb_d ? {base_digits[7:0], code_q[3:0]} : base_digits;
      count_d     = key_stb_d && base_count != 2'd3 ? base_count + 2'd1 : base_count;
      scan_d      = scan_q == SCAN_LAST ? 8'd0 : scan_q + 8'd1;
      sel_d       = scan_q == SCAN_LAST ? {sel_q[1:0], sel_q[2]} : sel_q;
   end
   // register bank: input sample, FSM state with registered outputs, buffer and scan
   always_ff @(posedge clk) begin
      if (!rst) begin
         code_q    <= 5'd0;
         cnt_q     <= 4'd0;
         state_q   <= IDLE;
         key_stb_q <= 1'b0;
         err_stb_q <= 1'b0;
         line_q    <= 10'd0;
         digits_q  <= 12'd0;
         count_q   <= 2'd0;
         scan_q    <= 8'd0;
         sel_q     <= 3'b001;
      end else begin
         code_q    <= code_in;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         key_stb_q <= key_stb_d;
         err_stb_q <= err_stb_d;
         line_q    <= line_d;
         digits_q  <= digits_d;
         count_q   <= count_d;
         scan_q    <= scan_d;
         sel_q     <= sel_d;
      end
   end
   // display mux: digit of the active position, blanked when not yet entered
   always_comb begin
      pos   = sel_q[0] ? 2'd0 : sel_q[1] ? 2'd1 : 2'd2;
      shown = sel_q[0] ? digits_q[3:0] : sel_q[1] ? digits_q[7:4] : digits_q[11:8];
      case (shown)
         4'd0:    seg_raw = 7'h3F;
         4'd1:    seg_raw = 7'h06;
         4'd2:    seg_raw = 7'h5B;
         4'd3:    seg_raw = 7'h4F;
         4'd4:    seg_raw = 7'h66;
         4'd5:    seg_raw = 7'h6D;
         4'd6:    seg_raw = 7'h7D;
         4'd7:    seg_raw = 7'h07;
         4'd8:    seg_raw = 7'h7F;
         4'd9:    seg_raw = 7'h6F;
         default: seg_raw = 7'h00;
      endcase
      seg_out = pos >= count_q ? 7'h00 : seg_raw;
   end
   assign key_stb  = key_stb_q;
   assign err_stb  = err_stb_q;
   assign line_out = line_q;
   assign digits   = digits_q;
   assign count    = count_q;
   assign full     = count_q == 2'd3;
   assign seg_sel  = sel_q;
endmodule

// File: tb/tb_keycode_decoder.sv
// tb_keycode_decoder: directed stimulus checked each cycle against a sliding-window behavioural model
module tb_keycode_decoder;
   localparam int HOLD = 2;
   localparam int SDIV = 4;
   logic        clk = 1'b0, rst = 1'b0, clr = 1'b0;
   logic [4:0]  code_in = 5'd0;
   logic        key_stb, err_stb, full;
   logic [9:0]  line_out;
   logic [11:0] digits;
   logic [1:0]  count;
   logic [2:0]  seg_sel;
   logic [6:0]  seg_out;
   keycode_decoder #(.HOLD_CYCLES(HOLD), .SCAN_DIV(SDIV)) dut (
      .clk(clk), .rst(rst), .code_in(code_in), .clr(clr),
      .key_stb(key_stb), .err_stb(err_stb), .line_out(line_out),
      .digits(digits), .count(count), .full(full),
      .seg_sel(seg_sel), .seg_out(seg_out)
   );
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   int hist [16];
   bit pressed;
   logic m_key, m_err;
   logic [9:0] m_line;
   logic [11:0] m_dig;
   logic [1:0] m_cnt;
   int n, pos, key_n, err_n, first;
   logic [6:0] m_seg;
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // a press/release is qualified when the last HOLD+1 sampled codes are identical
   task automatic model_edge();
      logic [4:0] c;
      bit st;
      if (!rst) begin
         m_key = 0; m_err = 0; m_line = 0; m_dig = 0; m_cnt = 0; pressed = 0; n = 0;
         for (int i = 0; i < 16; i++) hist[i] = -1 - i;
         hist[0] = 0;
      end else begin
         c = hist[0][4:0];
         st = 1;
         for (int i = 1; i <= HOLD; i++) if (hist[i] != hist[0]) st = 0;
         m_key = 0; m_err = 0;
         if (clr) begin m_dig = 0; m_cnt = 0; end
         if (!pressed && st && c[4]) begin
            pressed = 1;
            if (c[3:0] <= 9) begin
               m_key = 1;
               m_line = 10'd1 << c[3:0];
               m_dig = {m_dig[7:0], c[3:0]};
               if (m_cnt != 3) m_cnt++;
            end else m_err = 1;
         end else if (pressed && st && !c[4]) begin
            pressed = 0;
            m_line = 0;
         end
         for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = int'(code_in);
         n++;
      end
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      key_n += int'(key_stb);
      err_n += int'(err_stb);
      pos = (n / SDIV) % 3;
      m_seg = pos >= int'(m_cnt) ? 7'h00 : seg_tab[m_dig[pos*4 +: 4]];
      check("key_stb", key_stb, m_key);
      check("err_stb", err_stb, m_err);
      check("line_out", line_out, m_line);
      check("digits", digits, m_dig);
      check("count", count, m_cnt);
      check("full", full, m_cnt == 2'd3);
      check("seg_sel", seg_sel, 3'b001 << pos);
      check("seg_out", seg_out, m_seg);
   endtask
   task automatic run(input logic [4:0] c, input int cycles);
      code_in = c;
      repeat (cycles) step();
   endtask
   initial begin
      step(); step();
      check("rst_digits", digits, 12'h000);
      check("rst_seg_sel", seg_sel, 3'b001);
      check("rst_line", line_out, 10'h000);
      rst = 1;
      key_n = 0; first = -1; code_in = 5'b10111;
      for (int i = 0; i < 6; i++) begin
         step();
         if (key_stb && first < 0) first = i + 1;
      end
      check("t1_latency", first, 4);
      check("t1_pulses", key_n, 1);
      check("t1_line", line_out, 10'h080);
      check("t1_digits", digits, 12'h007);
      check("t1_count", count, 2'd1);
      run(5'b00000, 5);
      key_n = 0;
      for (int d = 1; d <= 4; d++) begin
         run({1'b1, 4'(d)}, 5);
         run(5'b00000, 5);
      end
      check("t2_pulses", key_n, 4);
      check("t2_digits", digits, 12'h234);
      check("t2_count", count, 2'd3);
      check("t2_full", full, 1'b1);
      key_n = 0;
      run(5'b10011, 2);
      run(5'b00000, 5);
      check("t3_glitch_pulses", key_n, 0);
      check("t3_glitch_digits", digits, 12'h234);
      for (int i = 0; i < 6; i++) run((i % 2) ? 5'b10100 : 5'b10011, 1);
      check("t3_bounce_pulses", key_n, 0);
      run(5'b10011, 5);
      check("t3_stable_pulses", key_n, 1);
      check("t3_digits", digits, 12'h343);
      run(5'b00000, 5);
      key_n = 0; err_n = 0;
      run(5'b11100, 5);
      check("t4_err_pulses", err_n, 1);
      check("t4_key_pulses", key_n, 0);
      check("t4_line", line_out, 10'h000);
      check("t4_digits", digits, 12'h343);
      run(5'b00000, 5);
      clr = 1; step(); clr = 0;
      check("t5_clr_count", count, 2'd0);
      run(5'b11000, 5); run(5'b00000, 5);
      run(5'b11001, 5); run(5'b00000, 5);
      check("t5_digits", digits, 12'h089);
      check("t5_count", count, 2'd2);
      for (int i = 0; i < 12; i++) begin
         step();
         if (seg_sel == 3'b001) check("t5_seg_d0", seg_out, 7'h6F);
         else if (seg_sel == 3'b010) check("t5_seg_d1", seg_out, 7'h7F);
         else check("t5_seg_d2", seg_out, 7'h00);
      end
      code_in = 5'b10101;
      step(); step(); step();
      clr = 1; step(); clr = 0;
      check("t5_clr_accept_stb", key_stb, 1'b1);
      check("t5_clr_accept_digits", digits, 12'h005);
      check("t5_clr_accept_count", count, 2'd1);
      run(5'b00000, 5);
      run(5'b10110, 5);
      check("t6_pre_digits", digits, 12'h056);
      rst = 0; step(); rst = 1;
      check("t6_rst_digits", digits, 12'h000);
      check("t6_rst_line", line_out, 10'h000);
      check("t6_rst_seg_sel", seg_sel, 3'b001);
      first = -1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (key_stb && first < 0) first = i + 1;
      end
      check("t6_latency", first, 4);
      check("t6_digits", digits, 12'h006);
      check("t6_line", line_out, 10'h040);
      run(5'b00000, 5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
